// File: rtl/alu_nibble_seq_pkg.sv
// Shared constants for the nibble-serial alu4 sequencer.
package alu_nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_nibble_seq.sv
// Runs a W-bit operation through an external 4-bit alu4 slice one nibble per clock,
// LSB nibble first, rippling Kout back in as Kin.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op_m,
  input  logic                op_ai,
  input  logic                op_bi,
  input  logic                carry_in,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        result,
  output logic                carry_out,
  output logic                zero,
  output logic [1:0]          alu_m,
  output logic                alu_ai,
  output logic                alu_bi,
  output logic [NIBBLE_W-1:0] alu_a,
  output logic [NIBBLE_W-1:0] alu_b,
  output logic                alu_kin,
  input  logic [NIBBLE_W-1:0] alu_out,
  input  logic                alu_kout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_next;
  logic [1:0]       m_lat;
  logic             ai_lat;
  logic             bi_lat;
  // Holds carry_in before nibble 0, then the registered Kout of the previous nibble.
  logic             kin_lat;
  logic [W-1:0]     result_lat;
  logic             carry_lat;
  logic             zero_lat;

  always_comb begin
    acc_next = acc;
    acc_next[int'(idx) * NIBBLE_W +: NIBBLE_W] = alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      m_lat      <= '0;
      ai_lat     <= 1'b0;
      bi_lat     <= 1'b0;
      kin_lat    <= 1'b0;
      result_lat <= '0;
      carry_lat  <= 1'b0;
      zero_lat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            m_lat   <= op_m;
            ai_lat  <= op_ai;
            bi_lat  <= op_bi;
            kin_lat <= carry_in;
            acc     <= '0;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc     <= acc_next;
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          kin_lat <= alu_kout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            result_lat <= acc_next;
            carry_lat  <= alu_kout;
            zero_lat   <= (acc_next == '0);
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          kin_lat <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign result    = result_lat;
  assign carry_out = carry_lat;
  assign zero      = zero_lat;

  assign alu_m   = m_lat;
  assign alu_ai  = ai_lat;
  assign alu_bi  = bi_lat;
  assign alu_a   = (state == ST_RUN) ? a_sh[NIBBLE_W-1:0] : '0;
  assign alu_b   = (state == ST_RUN) ? b_sh[NIBBLE_W-1:0] : '0;
  assign alu_kin = (state == ST_RUN) ? kin_lat : 1'b0;

endmodule
